// File: rtl/mfqs_sched_pkg.sv
// Shared definitions for the multi-FIFO queue scheduler: default sizes,
// queue-index width helper and FSM state encoding.
package mfqs_sched_pkg;

    localparam int DEF_WEIGHT_BITS = 4;

    typedef enum logic [0:0] {
        SCHED_IDLE   = 1'b0,
        SCHED_ACTIVE = 1'b1
    } sched_state_e;

    function automatic int qid_bits(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_next_select.sv
// Rotating-priority finder: returns the first set bit of eligible_i in the
// order cur+1, cur+2, ..., cur (modulo N), so cur itself is checked last.
module rr_next_select #(
    parameter int N        = 4,
    parameter int IDX_BITS = 2
) (
    input  logic [N-1:0]        eligible_i,
    input  logic [IDX_BITS-1:0] cur_i,
    output logic [IDX_BITS-1:0] nxt_o,
    output logic                found_o
);

    // Walk the ring once starting just after cur_i; the first hit wins.
    always_comb begin
        logic [IDX_BITS-1:0] idx_s;
        logic                hit_s;
        logic                take_s;
        nxt_o  = cur_i;
        hit_s  = 1'b0;
        idx_s  = '0;
        take_s = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx_s  = IDX_BITS'((int'(cur_i) + k) % N);
            take_s = !hit_s && eligible_i[idx_s];
            nxt_o  = take_s ? idx_s : nxt_o;
            hit_s  = hit_s | take_s;
        end
        found_o = hit_s;
    end

endmodule

// File: rtl/queue_wrr_scheduler.sv
// Weighted round-robin dequeue scheduler: pops one eligible queue head per
// cycle and forwards it through a registered valid/ready output stage.
module queue_wrr_scheduler
    import mfqs_sched_pkg::*;
#(
    parameter int  NUM_QUEUES  = 4,
    parameter int  WIDTH       = 32,
    parameter int  WEIGHT_BITS = DEF_WEIGHT_BITS,
    localparam int QID_BITS    = qid_bits(NUM_QUEUES)
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic [NUM_QUEUES*WIDTH-1:0]       q_data_i,
    input  logic [NUM_QUEUES-1:0]             q_valid_i,
    output logic [NUM_QUEUES-1:0]             q_pop_o,
    input  logic [NUM_QUEUES*WEIGHT_BITS-1:0] weight_i,
    input  logic                              weight_load_i,
    output logic [WIDTH-1:0]                  data_o,
    output logic [QID_BITS-1:0]               qid_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic                              active_o
);

    logic [NUM_QUEUES*WEIGHT_BITS-1:0] weight_q, weight_d;
    logic [QID_BITS-1:0]               cur_q, cur_d;
    logic [WEIGHT_BITS-1:0]            credit_q, credit_d;
    logic                              fresh_q, fresh_d;
    sched_state_e                      state_q, state_d;
    logic [WIDTH-1:0]                  data_q, data_d;
    logic [QID_BITS-1:0]               qid_q, qid_d;
    logic                              valid_q, valid_d;

    logic [NUM_QUEUES-1:0]             eligible_s;
    logic                              any_elig_s;
    logic                              slot_free_s;
    logic                              cur_elig_s;
    logic                              keep_s;
    logic                              grant_s;
    logic [QID_BITS-1:0]               base_s;
    logic [QID_BITS-1:0]               nxt_s;
    logic                              found_s;
    logic [QID_BITS-1:0]               g_s;
    logic [WIDTH-1:0]                  sel_data_s;
    logic [WEIGHT_BITS-1:0]            sel_weight_s;

    // Eligibility: head present and non-zero weight.
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            eligible_s[i] = q_valid_i[i] && (weight_q[i*WEIGHT_BITS +: WEIGHT_BITS] != '0);
        end
    end

    assign any_elig_s  = |eligible_s;
    assign slot_free_s = !valid_q || ready_i;

    // Straight after reset the search starts at queue 0 so the lowest
    // eligible index is served first; afterwards it rotates from cur.
    assign base_s = fresh_q ? QID_BITS'(NUM_QUEUES - 1) : cur_q;

    rr_next_select #(
        .N        (NUM_QUEUES),
        .IDX_BITS (QID_BITS)
    ) u_next_select (
        .eligible_i (eligible_s),
        .cur_i      (base_s),
        .nxt_o      (nxt_s),
        .found_o    (found_s)
    );

    // Eligibility of the queue holding the turn.
    always_comb begin
        cur_elig_s = 1'b0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (cur_q == QID_BITS'(i)) begin
                cur_elig_s = eligible_s[i];
            end else begin
                cur_elig_s = cur_elig_s;
            end
        end
    end

    assign keep_s  = cur_elig_s && (credit_q != '0) && !fresh_q;
    assign g_s     = keep_s ? cur_q : nxt_s;
    assign grant_s = slot_free_s && found_s;

    // Head word and weight of the granted queue; pop strobe masked by reset.
    always_comb begin
        sel_data_s   = '0;
        sel_weight_s = '0;
        q_pop_o      = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (g_s == QID_BITS'(i)) begin
                sel_data_s   = q_data_i[i*WIDTH +: WIDTH];
                sel_weight_s = weight_q[i*WEIGHT_BITS +: WEIGHT_BITS];
                q_pop_o[i]   = grant_s && rst_n_i;
            end else begin
                q_pop_o[i]   = 1'b0;
            end
        end
    end

    // Output stage, turn pointer, credit and weight next-state.
    always_comb begin
        data_d   = data_q;
        qid_d    = qid_q;
        valid_d  = valid_q;
        cur_d    = cur_q;
        credit_d = credit_q;
        fresh_d  = fresh_q;
        weight_d = weight_load_i ? weight_i : weight_q;
        if (grant_s) begin
            data_d  = sel_data_s;
            qid_d   = g_s;
            valid_d = 1'b1;
            fresh_d = 1'b0;
            if (keep_s) begin
                credit_d = credit_q - WEIGHT_BITS'(1);
            end else begin
                cur_d    = g_s;
                credit_d = sel_weight_s - WEIGHT_BITS'(1);
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SCHED_IDLE: begin
                if (any_elig_s) begin
                    state_d = SCHED_ACTIVE;
                end else begin
                    state_d = SCHED_IDLE;
                end
            end
            SCHED_ACTIVE: begin
                if (!any_elig_s && slot_free_s) begin
                    state_d = SCHED_IDLE;
                end else begin
                    state_d = SCHED_ACTIVE;
                end
            end
            default: state_d = SCHED_IDLE;
        endcase
    end

    // State registers; weights reset to 1 for plain round-robin.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                weight_q[i*WEIGHT_BITS +: WEIGHT_BITS] <= WEIGHT_BITS'(1);
            end
            cur_q    <= '0;
            credit_q <= '0;
            fresh_q  <= 1'b1;
            state_q  <= SCHED_IDLE;
            data_q   <= '0;
            qid_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            weight_q <= weight_d;
            cur_q    <= cur_d;
            credit_q <= credit_d;
            fresh_q  <= fresh_d;
            state_q  <= state_d;
            data_q   <= data_d;
            qid_q    <= qid_d;
            valid_q  <= valid_d;
        end
    end

    assign data_o   = data_q;
    assign qid_o    = qid_q;
    assign valid_o  = valid_q;
    assign active_o = (state_q == SCHED_ACTIVE);

endmodule

// File: tb/tb_queue_wrr_scheduler.sv
// Self-checking bench for queue_wrr_scheduler: upstream FIFOs are modelled as
// queues and each grant is predicted from the weighted round-robin rules.
module tb_queue_wrr_scheduler;

    localparam int NQ = 4;
    localparam int W  = 32;
    localparam int WB = 4;
    localparam int QB = 2;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic [NQ*W-1:0]   q_data_i;
    logic [NQ-1:0]     q_valid_i;
    logic [NQ-1:0]     q_pop_o;
    logic [NQ*WB-1:0]  weight_i;
    logic              weight_load_i;
    logic [W-1:0]      data_o;
    logic [QB-1:0]     qid_o;
    logic              valid_o;
    logic              ready_i;
    logic              active_o;

    always #5 clk_i = ~clk_i;

    queue_wrr_scheduler #(.NUM_QUEUES(NQ), .WIDTH(W), .WEIGHT_BITS(WB)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .q_data_i      (q_data_i),
        .q_valid_i     (q_valid_i),
        .q_pop_o       (q_pop_o),
        .weight_i      (weight_i),
        .weight_load_i (weight_load_i),
        .data_o        (data_o),
        .qid_o         (qid_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .active_o      (active_o)
    );

    typedef logic [W-1:0] word_q_t[$];
    word_q_t fifo [NQ];

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the turn, how many words it has left.
    int         m_w [NQ];
    int         m_turn;
    int         m_left;
    bit         m_fresh;
    bit         m_valid;
    bit         m_active;
    logic [W-1:0] m_data;
    int         m_qid;
    int         trace[$];

    function automatic bit elig(input int i);
        return (fifo[i].size() > 0) && (m_w[i] != 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NQ; i++) m_w[i] = 1;
        m_turn = 0; m_left = 0; m_fresh = 1'b1;
        m_valid = 1'b0; m_active = 1'b0; m_data = '0; m_qid = 0;
    endtask

    task automatic drive_heads();
        for (int i = 0; i < NQ; i++) begin
            if (fifo[i].size() > 0) begin
                q_valid_i[i]         = 1'b1;
                q_data_i[i*W +: W]   = fifo[i][0];
            end else begin
                q_valid_i[i]         = 1'b0;
                q_data_i[i*W +: W]   = '0;
            end
        end
    endtask

    task automatic push(input int q, input int n);
        for (int k = 0; k < n; k++) fifo[q].push_back($urandom);
    endtask

    task automatic do_reset(input bit clear);
        rst_n_i = 1'b0; ready_i = 1'b0; weight_load_i = 1'b0; weight_i = '0;
        if (clear) for (int i = 0; i < NQ; i++) fifo[i].delete();
        drive_heads();
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    // One clock: predict the grant, check the pop, advance, check outputs.
    task automatic step(input bit rdy, input bit wl, input logic [NQ*WB-1:0] wv);
        int g; int start; int idx; bit any; bit slot;
        logic [NQ-1:0] exp_pop;
        ready_i = rdy; weight_load_i = wl; weight_i = wv;
        drive_heads();
        #1;
        any = 1'b0;
        for (int i = 0; i < NQ; i++) any |= elig(i);
        slot = !m_valid || rdy;
        g = -1;
        if (slot && any) begin
            if (elig(m_turn) && m_left > 0 && !m_fresh) g = m_turn;
            else begin
                start = m_fresh ? 0 : (m_turn + 1) % NQ;
                for (int k = 0; k < NQ; k++) begin
                    idx = (start + k) % NQ;
                    if (g < 0 && elig(idx)) g = idx;
                end
            end
        end
        exp_pop = '0;
        if (g >= 0) exp_pop[g] = 1'b1;
        checks++;
        if (q_pop_o !== exp_pop) begin
            errors++;
            $display("FAIL pop: got %b exp %b at %0t", q_pop_o, exp_pop, $time);
        end
        @(posedge clk_i);
        if (g >= 0) begin
            m_data = fifo[g].pop_front();
            m_qid = g; m_valid = 1'b1; trace.push_back(g);
            if (g == m_turn && m_left > 0 && !m_fresh) m_left--;
            else begin m_turn = g; m_left = m_w[g] - 1; end
            m_fresh = 1'b0;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (!m_active) m_active = any;
        else if (!any && slot) m_active = 1'b0;
        if (wl) for (int i = 0; i < NQ; i++) m_w[i] = int'(wv[i*WB +: WB]);
        @(negedge clk_i);
        weight_load_i = 1'b0;
        checks++;
        if (valid_o !== m_valid) begin
            errors++;
            $display("FAIL valid: got %b exp %b at %0t", valid_o, m_valid, $time);
        end
        if (m_valid) begin
            checks++;
            if (data_o !== m_data || qid_o !== QB'(m_qid)) begin
                errors++;
                $display("FAIL word: got q%0d %h exp q%0d %h at %0t", qid_o, data_o, m_qid, m_data, $time);
            end
        end
        checks++;
        if (active_o !== m_active) begin
            errors++;
            $display("FAIL active: got %b exp %b at %0t", active_o, m_active, $time);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        for (int i = 0; i < NQ; i++) push(i, 1);
        rst_n_i = 1'b0; ready_i = 1'b1;
        drive_heads();
        #1;
        checks++;
        if (valid_o !== 1'b0 || data_o !== '0 || qid_o !== '0 || active_o !== 1'b0 || q_pop_o !== '0) begin
            errors++;
            $display("FAIL reset_state: v=%b d=%h q=%0d a=%b pop=%b exp all zero", valid_o, data_o, qid_o, active_o, q_pop_o);
        end
    endtask

    task automatic test_round_robin();
        do_reset(1'b1);
        for (int i = 0; i < NQ; i++) push(i, 3);
        trace.delete();
        repeat (14) step(1'b1, 1'b0, '0);
        checks++;
        if (trace.size() != 12) begin
            errors++;
            $display("FAIL rr_count: got %0d exp 12", trace.size());
        end
        for (int k = 0; k < trace.size() && k < 12; k++) begin
            checks++;
            if (trace[k] != k % 4) begin
                errors++;
                $display("FAIL rr_order k=%0d: got %0d exp %0d", k, trace[k], k % 4);
            end
        end
    endtask

    task automatic test_weights();
        int pat[6] = '{0, 0, 0, 1, 3, 3};
        do_reset(1'b1);
        step(1'b1, 1'b1, 16'h2013);
        for (int i = 0; i < NQ; i++) push(i, 8);
        trace.delete();
        repeat (12) step(1'b1, 1'b0, '0);
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (k >= trace.size() || trace[k] != pat[k % 6]) begin
                errors++;
                $display("FAIL wrr_order k=%0d: got %0d exp %0d", k, (k < trace.size()) ? trace[k] : -1, pat[k % 6]);
            end
        end
        checks++;
        if (fifo[2].size() != 8) begin
            errors++;
            $display("FAIL zero_weight: q2 left %0d exp 8", fifo[2].size());
        end
    endtask

    task automatic test_single_queue();
        do_reset(1'b1);
        step(1'b1, 1'b1, 16'h1211);
        push(2, 8);
        trace.delete();
        repeat (8) step(1'b1, 1'b0, '0);
        checks++;
        if (trace.size() != 8) begin
            errors++;
            $display("FAIL single_bubble: got %0d words exp 8", trace.size());
        end
    endtask

    task automatic test_forfeit();
        do_reset(1'b1);
        step(1'b1, 1'b1, 16'h1113);
        push(0, 1); push(1, 2);
        trace.delete();
        repeat (3) step(1'b1, 1'b0, '0);
        checks++;
        if (trace.size() != 3 || trace[0] != 0 || trace[1] != 1 || trace[2] != 1) begin
            errors++;
            $display("FAIL forfeit: got %0d words exp order 0,1,1", trace.size());
        end
    endtask

    task automatic test_max_weight();
        do_reset(1'b1);
        step(1'b1, 1'b1, 16'h11F1);
        push(0, 2); push(1, 20);
        trace.delete();
        repeat (17) step(1'b1, 1'b0, '0);
        for (int k = 0; k < 17; k++) begin
            checks++;
            if (k >= trace.size() || trace[k] != ((k == 0 || k == 16) ? 0 : 1)) begin
                errors++;
                $display("FAIL max_weight k=%0d: got %0d", k, (k < trace.size()) ? trace[k] : -1);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b1);
        for (int i = 0; i < NQ; i++) push(i, 4);
        trace.delete();
        repeat (2) step(1'b1, 1'b0, '0);
        repeat (5) step(1'b0, 1'b0, '0);
        checks++;
        if (trace.size() != 2) begin
            errors++;
            $display("FAIL bp_stall: got %0d grants exp 2", trace.size());
        end
        step(1'b1, 1'b0, '0);
        checks++;
        if (trace.size() != 3) begin
            errors++;
            $display("FAIL bp_resume: got %0d grants exp 3", trace.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b1);
        step(1'b1, 1'b1, 16'h2222);
        for (int i = 0; i < NQ; i++) push(i, 6);
        repeat (3) step(1'b1, 1'b0, '0);
        #2;
        rst_n_i = 1'b0;
        drive_heads();
        #1;
        checks++;
        if (valid_o !== 1'b0 || q_pop_o !== '0 || active_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: v=%b pop=%b a=%b exp 0", valid_o, q_pop_o, active_o);
        end
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        trace.delete();
        repeat (4) step(1'b1, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= trace.size() || trace[k] != k) begin
                errors++;
                $display("FAIL post_reset k=%0d: got %0d exp %0d", k, (k < trace.size()) ? trace[k] : -1, k);
            end
        end
    endtask

    task automatic test_random();
        logic [NQ*WB-1:0] wv;
        do_reset(1'b1);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3, 0) != 0) begin
                int q = $urandom_range(NQ - 1, 0);
                if (fifo[q].size() < 8) push(q, 1);
            end
            wv = NQ*WB'($urandom);
            step(($urandom_range(3, 0) != 0), ($urandom_range(19, 0) == 0), wv);
        end
    endtask

    initial begin
        q_data_i = '0; q_valid_i = '0; weight_i = '0; weight_load_i = 1'b0;
        ready_i = 1'b0; rst_n_i = 1'b0;
        model_reset();
        test_reset();
        test_round_robin();
        test_weights();
        test_single_queue();
        test_forfeit();
        test_max_weight();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/queue_wrr_scheduler.md
# queue_wrr_scheduler

Weighted round-robin dequeue scheduler placed downstream of `NUM_QUEUES` parallel FIFO queues. Each queue exposes a head word with a valid flag and accepts a one-cycle pop strobe. The block selects one head per cycle, pops it, and forwards the word and its queue index through a single registered valid/ready output. Per-queue weights are runtime-loadable and set how many consecutive words a queue may send before the turn passes on.

## Interface
Parameters:
- `NUM_QUEUES`, 4: number of upstream queues (≥2).
- `WIDTH`, 32: data word width.
- `WEIGHT_BITS`, 4: width of each queue's weight.

Ports:
- `clk_i`  in  1  single clock.
- `rst_n_i`  in  1  reset; asynchronous assert, active-low.
- `q_data_i`  in  `NUM_QUEUES*WIDTH`  head words; queue i at bits `[i*WIDTH +: WIDTH]`.
- `q_valid_i`  in  `NUM_QUEUES`  head-valid per queue.
- `q_pop_o`  out  `NUM_QUEUES`  one-hot pop strobe, combinational.
- `weight_i`  in  `NUM_QUEUES*WEIGHT_BITS`  new weights; queue i at bits `[i*WEIGHT_BITS +: WEIGHT_BITS]`.
- `weight_load_i`  in  1  strobe that captures `weight_i`.
- `data_o`  out  `WIDTH`  forwarded word.
- `qid_o`  out  `QID_BITS = max(1, $clog2(NUM_QUEUES))`  source queue of `data_o`.
- `valid_o`  out  1  output word valid.
- `ready_i`  in  1  downstream accept.
- `active_o`  out  1  FSM is in ACTIVE.

## Operation
Internal state:
- `weight_r[i]`: stored weight per queue.
- `cur`: current queue pointer.
- `credit`: remaining words for `cur`, `WEIGHT_BITS` wide.
- FSM state: IDLE or ACTIVE.

Selection:
- `eligible[i] = q_valid_i[i] && weight_r[i] != 0`. A queue with weight 0 is never served.
- `slot_free = !valid_o || ready_i`.
- `nxt` is the first eligible queue in the search order cur+1, cur+2, …, cur+N−1, cur (modulo N). `cur` is checked last.
- Target: `g = (eligible[cur] && credit != 0) ? cur : nxt`.
- A grant happens when `slot_free` and any queue is eligible.

On a grant:
- `q_pop_o[g] = 1` in the same cycle.
- `data_o <= q_data_i[g]`, `qid_o <= g`, `valid_o <= 1`.
- If `g == cur` and `credit != 0`: `credit <= credit - 1`.
- Otherwise: `cur <= g` and `credit <= weight_r[g] - 1`.

With no grant and `valid_o && ready_i`, set `valid_o <= 0`.

`q_pop_o` is all-zero whenever there is no grant, and while `rst_n_i` is low.

FSM:
- IDLE → ACTIVE when any queue is eligible.
- ACTIVE → IDLE when no queue is eligible and `valid_o` is 0 or is being consumed this cycle.

Weights:
- `weight_load_i` writes `weight_r <= weight_i`.
- A loaded weight takes effect at the next credit reload. The current `credit` is unchanged.
- When `weight_load_i` coincides with a reload, the reload uses the old `weight_r`.

Reset (asynchronous):
- `valid_o = 0`, `data_o = 0`, `qid_o = 0`, `active_o = 0`.
- `cur = 0`, `credit = 0`, every `weight_r = 1` (plain round-robin).

## Timing
- Latency is 1 cycle: if queue i is eligible and `slot_free` in cycle t, then `valid_o = 1` with its word in cycle t+1.
- Throughput is 1 word/cycle while `ready_i` stays high.
- Backpressure: `valid_o`, `data_o` and `qid_o` are held stable while `valid_o && !ready_i`. No pop occurs in those cycles.
- A queue is never popped twice within one cycle. The upstream queue updates `q_valid_i` at the next clock edge.
- An empty `cur` causes no lost cycle: the grant falls through to `nxt` in the same cycle.
- If `cur` becomes ineligible mid-turn, its remaining credit is forfeited.
- When `cur` is the only eligible queue and its credit is 0, it is reloaded and served again with no bubble.
- Weight `2^WEIGHT_BITS − 1` gives 15 consecutive words at the default width.
- Reset during a transfer drops the output word. Upstream words are never lost, because pops are masked while reset is asserted.

## Structure
- Package `mfqs_sched_pkg` holds:
  - default `WEIGHT_BITS`;
  - the `QID_BITS` computation function;
  - the FSM state encoding, `SCHED_IDLE` and `SCHED_ACTIVE`.
- Sub-module `rr_next_select`: combinational rotating-priority finder. It takes `eligible` and `cur` and returns `nxt` plus a `found` flag. It is reusable by other arbiters in the design.

## Test plan
- After reset, with all 4 queues holding 3 words each and default weights: order is qid 0,1,2,3,0,1,2,3,…; one word per cycle; 12 pops total.
- Weights {3,1,0,2} loaded, all queues non-empty: repeating order 0,0,0,1,3,3. Queue 2 is never popped.
- Only queue 2 valid, weight 2, `ready_i` held high: every cycle a word from qid 2, credit reloads with no bubble.
- Queue 0 empties after 1 of its 3 credits: the next cycle grants queue 1 directly, with no idle cycle.
- `ready_i` low for 5 cycles while `valid_o` is high: `data_o` and `qid_o` are stable and `q_pop_o` is 0 throughout. The transfer completes on the first cycle `ready_i` is high.
- `rst_n_i` pulsed low asynchronously mid-stream: `valid_o` and `q_pop_o` drop immediately and weights return to 1. The first grant after release comes from the lowest eligible queue index.
